vga_hex_reader: RTL



---
 rtl/vga_hex_reader_pkg.sv | 31 +++
 rtl/vga_hex_font.sv | 54 +++++
 rtl/vga_hex_reader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_hex_reader_pkg.sv
//==============================================================================
// vga_pkg : shared timing defaults, text-grid geometry and types for the
//           debug VGA hex reader.
// Rev 1.0
//==============================================================================
`default_nettype none

package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int CELL_H        = 10;
  localparam int GLYPH_ROWS    = 8;
  localparam int CHARS_PER_ROW = 40;
  localparam int ROW_BITS      = 4 * CHARS_PER_ROW;
  localparam int TEXT_ROWS     = 48;
  // One spare code so the row index can step past the last row at frame end.
  localparam int ROW_IDX_W     = $clog2(TEXT_ROWS + 1);

  typedef logic [3:0] nibble_t;

endpackage

`default_nettype wire

// File: rtl/vga_hex_font.sv
//==============================================================================
// vga_hex_font : combinational 8x8 glyph ROM for hex digits 0-9, A-F.
// Rev 1.0
//==============================================================================
`default_nettype none

module vga_hex_font (
  input  logic [3:0] nibble,
  input  logic [2:0] row,
  output logic [7:0] bits
);

  logic [63:0] w_glyph;

  // Each glyph is eight rows top to bottom, bit 7 of a row is the leftmost pixel.
  always_comb begin
    w_glyph = '0;
    case (nibble)
      4'h0:    w_glyph = 64'h3C666E7666663C00;
      4'h1:    w_glyph = 64'h183818181818_7E00;
      4'h2:    w_glyph = 64'h3C66060C30607E00;
      4'h3:    w_glyph = 64'h3C66061C06663C00;
      4'h4:    w_glyph = 64'h0C1C3C6C7E0C0C00;
      4'h5:    w_glyph = 64'h7E607C0606663C00;
      4'h6:    w_glyph = 64'h3C607C6666663C00;
      4'h7:    w_glyph = 64'h7E060C1830303000;
      4'h8:    w_glyph = 64'h3C66663C66663C00;
      4'h9:    w_glyph = 64'h3C66663E060C3800;
      4'hA:    w_glyph = 64'h183C66667E666600;
      4'hB:    w_glyph = 64'h7C66667C66667C00;
      4'hC:    w_glyph = 64'h3C66606060663C00;
      4'hD:    w_glyph = 64'h786C6666666C7800;
      4'hE:    w_glyph = 64'h7E60607C60607E00;
      default: w_glyph = 64'h7E60607C60606000;
    endcase
  end

  always_comb begin
    bits = '0;
    case (row)
      3'd0:    bits = w_glyph[63:56];
      3'd1:    bits = w_glyph[55:48];
      3'd2:    bits = w_glyph[47:40];
      3'd3:    bits = w_glyph[39:32];
      3'd4:    bits = w_glyph[31:24];
      3'd5:    bits = w_glyph[23:16];
      3'd6:    bits = w_glyph[15:8];
      default: bits = w_glyph[7:0];
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vga_hex_reader.sv
//==============================================================================
// vga_hex_reader : 640x480@60 VGA scan that fetches one 160-bit RAM row per
//                  10-line text cell and renders it as 40 hex glyphs.
// Rev 1.0
//==============================================================================
`default_nettype none

module vga_hex_reader
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ROW_BITS-1:0] ram_out,
  output logic [31:0]         read_address,
  output logic                hsync,
  output logic                vsync,
  output logic                video_on,
  output logic                pixel,
  output logic                frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int CELL_W  = $clog2(CELL_H);

  localparam logic [H_W-1:0]    H_LAST_C     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]    H_VIS_C      = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0]    HS_START_C   = H_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_W-1:0]    HS_END_C     = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0]    V_LAST_C     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]    V_VIS_C      = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0]    V_VIS_LAST_C = V_W'(V_VISIBLE - 1);
  localparam logic [V_W-1:0]    VS_START_C   = V_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_W-1:0]    VS_END_C     = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CELL_W-1:0] CELL_LAST_C  = CELL_W'(CELL_H - 1);
  localparam logic [CELL_W-1:0] GLYPH_C      = CELL_W'(GLYPH_ROWS);

  logic [H_W-1:0]       h_cnt_q, h_cnt_d;
  logic [V_W-1:0]       v_cnt_q, v_cnt_d;
  logic [CELL_W-1:0]    cell_line_q, cell_line_d;
  logic [ROW_IDX_W-1:0] text_row_q, text_row_d;
  logic [ROW_IDX_W-1:0] addr_q, addr_d;
  logic [ROW_BITS-1:0]  row_buf_q, row_buf_d;
  logic                 hsync_q, vsync_q, video_on_q, pixel_q, frame_start_q;

  logic                 w_video;
  logic [H_W-5:0]       w_nib_idx;
  nibble_t              w_nibble;
  logic [7:0]           w_font_bits;
  logic                 w_pixel_raw;

  always_comb begin
    h_cnt_d     = h_cnt_q + 1'b1;
    v_cnt_d     = v_cnt_q;
    cell_line_d = cell_line_q;
    text_row_d  = text_row_q;
    addr_d      = addr_q;
    row_buf_d   = row_buf_q;

    // Next row address goes out at the start of blanking so it settles long before the latch.
    if (h_cnt_q == H_VIS_C && v_cnt_q < V_VIS_C && cell_line_q == CELL_LAST_C) begin
      addr_d = (v_cnt_q == V_VIS_LAST_C) ? '0 : text_row_q + 1'b1;
    end

    if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST_C) begin
        v_cnt_d     = '0;
        cell_line_d = '0;
        text_row_d  = '0;
        row_buf_d   = ram_out;
      end else begin
        v_cnt_d = v_cnt_q + 1'b1;
        if (v_cnt_q < V_VIS_C) begin
          if (cell_line_q == CELL_LAST_C) begin
            cell_line_d = '0;
            text_row_d  = text_row_q + 1'b1;
            if (v_cnt_q != V_VIS_LAST_C) begin
              row_buf_d = ram_out;
            end
          end else begin
            cell_line_d = cell_line_q + 1'b1;
          end
        end
      end
    end
  end

  assign w_video   = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
  assign w_nib_idx = h_cnt_q[H_W-1:4];

  // Leftmost character comes from the most significant nibble of the row word.
  always_comb begin
    w_nibble = '0;
    for (int i = 0; i < CHARS_PER_ROW; i++) begin
      if (w_nib_idx == (H_W-4)'(i)) begin
        w_nibble = row_buf_q[ROW_BITS-1-4*i -: 4];
      end
    end
  end

  vga_hex_font u_font (
    .nibble (w_nibble),
    .row    (cell_line_q[2:0]),
    .bits   (w_font_bits)
  );

  // Each font column spans two pixels, so the column index drops h[0].
  assign w_pixel_raw = w_video && (cell_line_q < GLYPH_C) && w_font_bits[~h_cnt_q[3:1]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      cell_line_q   <= '0;
      text_row_q    <= '0;
      addr_q        <= '0;
      row_buf_q     <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pixel_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      cell_line_q   <= cell_line_d;
      text_row_q    <= text_row_d;
      addr_q        <= addr_d;
      row_buf_q     <= row_buf_d;
      hsync_q       <= !((h_cnt_q >= HS_START_C) && (h_cnt_q < HS_END_C));
      vsync_q       <= !((v_cnt_q >= VS_START_C) && (v_cnt_q < VS_END_C));
      video_on_q    <= w_video;
      pixel_q       <= w_pixel_raw;
      frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  assign read_address = {{(32-ROW_IDX_W){1'b0}}, addr_q};
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_on     = video_on_q;
  assign pixel        = pixel_q;
  assign frame_start  = frame_start_q;

endmodule

`default_nettype wire
